pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-latch enable/flush, sequences the outstanding data-memory access held in EX/MEM against instruction fetch, inserts load-use bubbles and flushes on MEM-stage redirects.
- Drains and freezes the pipeline on halt.
- Sits beside the datapath; it consumes EX/MEM and ID/EX control outputs and drives every latch's stall/flush inputs.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/load_use_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-select width and the hazard-controller state encoding.
package cpu_types_pkg;

  localparam int unsigned RegBits = 5;

  typedef logic [RegBits-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    DDONE,
    DRAIN,
    HALTED
  } hzstate_t;

  // True in the states where the pipeline may advance.
  function automatic logic is_active(hzstate_t s);
    return (s == RUN) || (s == DDONE);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register the IF/ID instruction reads.
module load_use_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_dren_i,
  input  logic [REG_W-1:0] ex_wsel_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             hazard_o
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (ex_wsel_i == id_rs_i);
    rt_match = id_uses_rt_i && (ex_wsel_i == id_rt_i);
    // $0 is hardwired, so a load targeting it never creates a dependency.
    hazard_o = ex_dren_i && (ex_wsel_i != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: latch enables/flushes, data-access sequencing, load-use bubbles,
// MEM-stage redirects, halt drain and a saturating stall counter.
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dREN,
  output logic             dWEN,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  hzstate_t         state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             data_ok;
  logic             adv;
  logic             stall_inc;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .ex_dren_i    (ex_dREN),
    .ex_wsel_i    (ex_wsel),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .hazard_o     (load_use)
  );

  always_comb begin
    data_ok = !(mem_dREN || mem_dWEN) || dhit || (state_q == DDONE);
    adv     = is_active(state_q) && ihit && data_ok;
  end

  always_comb begin
    state_d     = state_q;
    stall_inc   = 1'b0;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;

    case (state_q)
      RUN, DDONE: begin
        if (!adv) begin
          // Freeze the front, bubble WB so a held instruction never writes back twice.
          memwb_flush = 1'b1;
          stall_inc   = 1'b1;
          if ((state_q == RUN) && dhit && !ihit) begin
            state_d = DDONE;
          end
        end else if (mem_halt) begin
          memwb_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          state_d     = DRAIN;
        end else if (mem_redirect) begin
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          state_d     = RUN;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
          state_d = RUN;
        end
      end
      DRAIN: begin
        state_d = HALTED;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    dREN = mem_dREN && (state_q == RUN);
    dWEN = mem_dWEN && (state_q == RUN);

    // Reset silences every request combinationally, abandoning any access in flight.
    if (!nRST) begin
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      dREN        = 1'b0;
      dWEN        = 1'b0;
      halted      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        CLK;
  logic        nRST;
  logic        ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, mem_halt, ex_dREN, id_uses_rt;
  logic [4:0]  ex_wsel, id_rs, id_rt;
  logic        pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, dREN, dWEN, halted;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_hazard_ctrl #(
    .REG_W (5),
    .CNT_W (16)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_dREN     (mem_dREN),
    .mem_dWEN     (mem_dWEN),
    .mem_redirect (mem_redirect),
    .mem_halt     (mem_halt),
    .ex_dREN      (ex_dREN),
    .ex_wsel      (ex_wsel),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .pc_en        (pc_en),
    .pc_redirect  (pc_redirect),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .dREN         (dREN),
    .dWEN         (dWEN),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 1'b0; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    mem_redirect = 1'b0; mem_halt = 1'b0; ex_dREN = 1'b0; id_uses_rt = 1'b0;
    ex_wsel = '0; id_rs = '0; id_rt = '0;
  endtask

  initial begin
    clear_inputs();
    nRST = 1'b0;
    ihit = 1'b1;
    mem_dREN = 1'b1;
    mem_dWEN = 1'b1;
    #2;
    // Reset: every output quiet even with requests pending on the inputs.
    check_eq("rst_pc_en", pc_en, 0);
    check_eq("rst_memwb_en", memwb_en, 0);
    check_eq("rst_dREN", dREN, 0);
    check_eq("rst_dWEN", dWEN, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    tick(); tick();
    nRST = 1'b1;
    clear_inputs();

    // Load waits 3 cycles for dhit.
    ihit = 1'b1; mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("ld_wait_dREN", dREN, 1);
      check_eq("ld_wait_memwb_flush", memwb_flush, 1);
      check_eq("ld_wait_pc_en", pc_en, 0);
      check_eq("ld_wait_exmem_en", exmem_en, 0);
      tick();
    end
    dhit = 1'b1;
    #1;
    check_eq("ld_done_pc_en", pc_en, 1);
    check_eq("ld_done_ifid_en", ifid_en, 1);
    check_eq("ld_done_memwb_flush", memwb_flush, 0);
    check_eq("ld_done_cnt", stall_cnt, 3);
    tick();
    check_eq("ld_after_cnt", stall_cnt, 3);

    // dhit before ihit: DDONE holds the data, no reissue.
    ihit = 1'b0; dhit = 1'b1; mem_dREN = 1'b1;
    #1;
    check_eq("dd_first_dREN", dREN, 1);
    check_eq("dd_first_pc_en", pc_en, 0);
    tick();
    dhit = 1'b0;
    #1;
    check_eq("dd_wait_dREN", dREN, 0);
    check_eq("dd_wait_memwb_flush", memwb_flush, 1);
    check_eq("dd_wait_pc_en", pc_en, 0);
    tick();
    ihit = 1'b1;
    #1;
    check_eq("dd_adv_pc_en", pc_en, 1);
    check_eq("dd_adv_memwb_en", memwb_en, 1);
    check_eq("dd_adv_dREN", dREN, 0);
    tick();
    mem_dREN = 1'b0;
    check_eq("dd_cnt", stall_cnt, 5);

    // Load-use on rt.
    ex_dREN = 1'b1; ex_wsel = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1; id_rs = 5'd3;
    #1;
    check_eq("lu_rt_pc_en", pc_en, 0);
    check_eq("lu_rt_ifid_en", ifid_en, 0);
    check_eq("lu_rt_idex_flush", idex_flush, 1);
    check_eq("lu_rt_exmem_en", exmem_en, 1);
    check_eq("lu_rt_memwb_en", memwb_en, 1);
    tick();
    check_eq("lu_rt_cnt", stall_cnt, 6);
    // $0 destination: no bubble.
    ex_wsel = 5'd0; id_rt = 5'd0;
    #1;
    check_eq("lu_zero_pc_en", pc_en, 1);
    check_eq("lu_zero_idex_flush", idex_flush, 0);
    tick();
    // rs match.
    ex_wsel = 5'd8; id_rs = 5'd8; id_rt = 5'd2;
    #1;
    check_eq("lu_rs_idex_flush", idex_flush, 1);
    tick();
    // rt match but rt unused.
    id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
    #1;
    check_eq("lu_unused_pc_en", pc_en, 1);
    check_eq("lu_unused_idex_flush", idex_flush, 0);
    tick();
    check_eq("lu_cnt", stall_cnt, 7);

    // Redirect overrides a load-use hazard.
    id_rs = 5'd8; mem_redirect = 1'b1;
    #1;
    check_eq("rd_pc_redirect", pc_redirect, 1);
    check_eq("rd_pc_en", pc_en, 1);
    check_eq("rd_ifid_flush", ifid_flush, 1);
    check_eq("rd_idex_flush", idex_flush, 1);
    check_eq("rd_exmem_flush", exmem_flush, 1);
    check_eq("rd_memwb_en", memwb_en, 1);
    check_eq("rd_memwb_flush", memwb_flush, 0);
    tick();
    check_eq("rd_cnt", stall_cnt, 7);
    // Redirect without ihit is a plain stall.
    ihit = 1'b0;
    #1;
    check_eq("rd_noadv_pc_redirect", pc_redirect, 0);
    check_eq("rd_noadv_pc_en", pc_en, 0);
    tick();
    check_eq("rd_noadv_cnt", stall_cnt, 8);

    // Halt wins over redirect, then DRAIN, then HALTED.
    ihit = 1'b1; ex_dREN = 1'b0; mem_halt = 1'b1;
    #1;
    check_eq("hl_pc_en", pc_en, 0);
    check_eq("hl_pc_redirect", pc_redirect, 0);
    check_eq("hl_memwb_en", memwb_en, 1);
    check_eq("hl_ifid_flush", ifid_flush, 1);
    check_eq("hl_exmem_flush", exmem_flush, 1);
    check_eq("hl_halted", halted, 0);
    tick();
    #1;
    check_eq("drain_pc_en", pc_en, 0);
    check_eq("drain_memwb_en", memwb_en, 0);
    check_eq("drain_memwb_flush", memwb_flush, 0);
    check_eq("drain_halted", halted, 0);
    tick();
    ihit = 1'b0; mem_dREN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("halt_halted", halted, 1);
      check_eq("halt_dREN", dREN, 0);
      check_eq("halt_memwb_en", memwb_en, 0);
      check_eq("halt_memwb_flush", memwb_flush, 0);
      tick();
    end
    check_eq("halt_cnt", stall_cnt, 8);
    nRST = 1'b0;
    #1;
    check_eq("halt_rst_cnt", stall_cnt, 0);
    check_eq("halt_rst_halted", halted, 0);
    tick();
    nRST = 1'b1;
    clear_inputs();
    ihit = 1'b1;
    #1;
    check_eq("post_rst_pc_en", pc_en, 1);

    // Async reset drops an in-flight request immediately.
    mem_dWEN = 1'b1;
    #1;
    check_eq("async_dWEN_before", dWEN, 1);
    nRST = 1'b0;
    #1;
    check_eq("async_dWEN_after", dWEN, 0);
    tick();
    nRST = 1'b1;
    clear_inputs();

    // 2^16 + 5 stall cycles saturate the counter.
    for (int i = 0; i < 65534; i++) tick();
    check_eq("sat_pre", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 7; i++) tick();
    check_eq("sat_cnt", stall_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
